pwm_sample_feeder: RTL and testbench

Upstream feeder for the PWM output stage. It accepts signed audio/control samples over a valid/ready handshake and buffers them in a small FIFO. It converts each sample to an unsigned offset-binary duty word with rounding and saturation, and presents a new duty word exactly once per PWM frame. Between updates the output is held stable, so the PWM never sees a duty change mid-period.

---
 rtl/pwm_sample_feeder.sv | 113 +++++++++++
 tb/tb_pwm_sample_feeder.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_sample_feeder.sv
// pwm_sample_feeder: buffers signed samples in a small FIFO and hands one
// rounded, saturated offset-binary duty word to the PWM stage per frame.
// Data_out only moves on frame boundaries, so a PWM period never sees a
// duty change part-way through.
module pwm_sample_feeder #(
    parameter int IN_Width   = 12,
    parameter int PWM_Width  = 8,
    parameter int FRAME_LEN  = 9984,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [IN_Width-1:0] Sample_in,
    input  logic                       Sample_valid,
    output logic                       Sample_ready,
    output logic [PWM_Width-1:0]       Data_out,
    output logic                       Frame_strobe,
    output logic                       Underrun,
    input  logic                       Underrun_clr,
    output logic [DEPTH_LOG2:0]        Level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    // Half an output LSB expressed in input LSBs: adding it before truncation
    // rounds half up.
    localparam logic [IN_Width:0] RND = (IN_Width+1)'(1) << (IN_Width-PWM_Width-1);

    logic [CW-1:0]         r_cnt;
    logic [IN_Width-1:0]   r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr;
    logic [DEPTH_LOG2-1:0] r_rd;
    logic [DEPTH_LOG2:0]   r_level;
    logic [PWM_Width-1:0]  r_data;
    logic                  r_strobe;
    logic                  r_unr;

    logic                  w_bnd;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [IN_Width-1:0]   w_head;
    logic [IN_Width-1:0]   w_u;
    logic [IN_Width:0]     w_r;
    logic [PWM_Width:0]    w_d;
    logic [PWM_Width-1:0]  w_conv;

    assign w_bnd        = (r_cnt == CW'(FRAME_LEN - 1));
    assign w_empty      = (r_level == '0);
    assign Sample_ready = (r_level != (DEPTH_LOG2+1)'(DEPTH));
    assign w_push       = Sample_valid && Sample_ready;
    // Pop decision uses the pre-edge level, so a push landing on an empty
    // FIFO at a boundary waits for the next boundary.
    assign w_pop        = w_bnd && !w_empty;

    // Head conversion: flip MSB to offset binary, round, keep top bits, clamp.
    always_comb begin
        w_head = r_mem[r_rd];
        w_u    = {~w_head[IN_Width-1], w_head[IN_Width-2:0]};
        w_r    = {1'b0, w_u} + RND;
        w_d    = w_r[IN_Width:IN_Width-PWM_Width];
        w_conv = w_d[PWM_Width] ? '1 : w_d[PWM_Width-1:0];
    end

    // Free-running frame counter; the wrap edge is the frame boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_cnt <= '0;
        else if (w_bnd) r_cnt <= '0;
        else            r_cnt <= r_cnt + CW'(1);
    end

    // FIFO storage; contents need no reset since pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= Sample_in;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + DEPTH_LOG2'(1);
            if (w_pop)  r_rd <= r_rd + DEPTH_LOG2'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (DEPTH_LOG2+1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Duty word, frame strobe and sticky underrun, all updated at boundaries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data   <= PWM_Width'(1) << (PWM_Width-1);
            r_strobe <= 1'b0;
            r_unr    <= 1'b0;
        end else begin
            r_strobe <= w_bnd;
            if (w_pop) r_data <= w_conv;
            if (w_bnd && w_empty) r_unr <= 1'b1;
            else if (Underrun_clr) r_unr <= 1'b0;
        end
    end

    assign Data_out     = r_data;
    assign Frame_strobe = r_strobe;
    assign Underrun     = r_unr;
    assign Level        = r_level;

endmodule

// File: tb/tb_pwm_sample_feeder.sv
// Scoreboard bench for pwm_sample_feeder with a short frame (16 clk).
module tb_pwm_sample_feeder;

    logic              clk = 1'b0;
    logic              rst;
    logic signed [11:0] Sample_in;
    logic              Sample_valid;
    logic              Sample_ready;
    logic [7:0]        Data_out;
    logic              Frame_strobe;
    logic              Underrun;
    logic              Underrun_clr;
    logic [2:0]        Level;

    pwm_sample_feeder #(
        .IN_Width(12), .PWM_Width(8), .FRAME_LEN(16), .DEPTH_LOG2(2)
    ) dut (
        .clk(clk), .rst(rst), .Sample_in(Sample_in), .Sample_valid(Sample_valid),
        .Sample_ready(Sample_ready), .Data_out(Data_out), .Frame_strobe(Frame_strobe),
        .Underrun(Underrun), .Underrun_clr(Underrun_clr), .Level(Level)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference conversion in plain integer arithmetic.
    function automatic int conv(input int x);
        int d;
        d = (x + 2048 + 8) / 16;
        if (d > 255) d = 255;
        return d;
    endfunction

    // Reference model / scoreboard
    int exp_q[$];
    int obs_q[$];
    int mdl_cnt;
    int mdl_data;
    bit mdl_unr, mdl_strobe, mdl_popped;
    bit mon_en = 0;
    bit log_en = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            mdl_cnt    <= 0;
            mdl_data   <= 128;
            mdl_unr    <= 0;
            mdl_strobe <= 0;
            mdl_popped <= 0;
        end else begin
            automatic bit bnd = (mdl_cnt == 15);
            automatic int sz  = exp_q.size();
            mdl_popped <= bnd && sz > 0;
            if (bnd && sz > 0) mdl_data <= exp_q.pop_front();
            if (Sample_valid && sz < 4) exp_q.push_back(conv(int'(Sample_in)));
            if (bnd && sz == 0) mdl_unr <= 1;
            else if (Underrun_clr) mdl_unr <= 0;
            mdl_strobe <= bnd;
            mdl_cnt    <= bnd ? 0 : mdl_cnt + 1;
        end
    end

    // Compare every DUT output against the model away from the active edge.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("level", int'(Level), exp_q.size());
            chk("ready", int'(Sample_ready), int'(exp_q.size() < 4));
            chk("strobe", int'(Frame_strobe), int'(mdl_strobe));
            chk("underrun", int'(Underrun), int'(mdl_unr));
            chk("data", int'(Data_out), mdl_data);
            if (log_en && mdl_strobe && mdl_popped) obs_q.push_back(int'(Data_out));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Return when the next rising edge is a frame boundary.
    task automatic wait_bnd;
        for (int i = 0; i < 40; i++) begin
            if (mdl_cnt == 15) return;
            tick();
        end
        chk("wait_bnd_timeout", 0, 1);
    endtask

    task automatic push(input int x);
        bit hs;
        hs = 0;
        Sample_in    = 12'(x);
        Sample_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            hs = Sample_ready;
            tick();
            if (hs) break;
        end
        Sample_valid = 1'b0;
        if (!hs) chk("push_timeout", 0, 1);
    endtask

    task automatic drain;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) return;
            tick();
        end
        chk("drain_timeout", 0, 1);
    endtask

    int conv_exp[5] = '{0, 128, 134, 255, 128};

    initial begin
        rst = 1'b1; Sample_in = '0; Sample_valid = 1'b0; Underrun_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", int'(Data_out), 128);
        chk("rst_level", int'(Level), 0);
        chk("rst_unr", int'(Underrun), 0);
        chk("rst_ready", int'(Sample_ready), 1);
        rst = 1'b0;
        mon_en = 1;

        // Idle: first boundary underruns and keeps midscale.
        for (int i = 0; i < 15; i++) tick();
        chk("idle_no_strobe_yet", int'(Frame_strobe), 0);
        tick();
        chk("idle_strobe", int'(Frame_strobe), 1);
        chk("idle_unr", int'(Underrun), 1);
        chk("idle_data", int'(Data_out), 128);

        // Underrun clear.
        Underrun_clr = 1'b1; tick(); Underrun_clr = 1'b0;
        chk("unr_clr", int'(Underrun), 0);

        // Conversion and backpressure: 5 samples into a 4-deep FIFO.
        wait_bnd(); tick();
        obs_q.delete();
        log_en = 1;
        push(-2048); push(0); push(100); push(2047);
        chk("full_ready", int'(Sample_ready), 0);
        chk("full_level", int'(Level), 4);
        push(-1);
        chk("bp_level", int'(Level), 4);
        drain(); tick();
        log_en = 0;
        chk("conv_count", obs_q.size(), 5);
        for (int i = 0; i < 5 && i < obs_q.size(); i++) chk("conv_val", obs_q[i], conv_exp[i]);

        // Simultaneous push/pop with Level=2.
        wait_bnd(); tick();
        push(100); push(200);
        wait_bnd();
        Sample_in = 12'(300); Sample_valid = 1'b1; tick(); Sample_valid = 1'b0;
        chk("sim_level", int'(Level), 2);
        chk("sim_data0", int'(Data_out), 134);
        wait_bnd(); tick();
        chk("sim_data1", int'(Data_out), 141);
        wait_bnd(); tick();
        chk("sim_data2", int'(Data_out), 147);

        // Push into empty FIFO on the boundary edge.
        drain();
        wait_bnd(); tick();
        Underrun_clr = 1'b1; tick(); Underrun_clr = 1'b0;
        chk("pre_unr", int'(Underrun), 0);
        wait_bnd();
        Sample_in = 12'(1000); Sample_valid = 1'b1; tick(); Sample_valid = 1'b0;
        chk("ebp_unr", int'(Underrun), 1);
        chk("ebp_data", int'(Data_out), 147);
        chk("ebp_level", int'(Level), 1);
        wait_bnd(); tick();
        chk("ebp_next", int'(Data_out), 191);

        // Clear collides with a new underrun: set wins.
        wait_bnd(); tick();
        Underrun_clr = 1'b1; tick(); Underrun_clr = 1'b0;
        chk("clr_b4", int'(Underrun), 0);
        wait_bnd();
        Underrun_clr = 1'b1; tick(); Underrun_clr = 1'b0;
        chk("clr_collide", int'(Underrun), 1);

        // Asynchronous reset mid-frame with data queued.
        push(500); push(-700);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_data", int'(Data_out), 128);
        chk("arst_level", int'(Level), 0);
        chk("arst_unr", int'(Underrun), 0);
        chk("arst_ready", int'(Sample_ready), 1);
        chk("arst_strobe", int'(Frame_strobe), 0);
        tick(); tick();
        rst = 1'b0;

        // Random traffic checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            Sample_in    = 12'($urandom_range(0, 4095));
            Sample_valid = ($urandom_range(0, 5) == 0);
            Underrun_clr = ($urandom_range(0, 20) == 0);
            tick();
        end
        Sample_valid = 1'b0; Underrun_clr = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
